ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage. It consumes the ID/EX register outputs
//  (operands and a decoded mul/div op) and produces the HI/LO architectural registers.

---
 rtl/ex_muldiv_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative EX-stage multiply/divide unit owning the HI/LO
//                registers. Signed/unsigned shift-add multiply, restoring
//                divide, MTHI/MTLO writes, pipeline stall and flush handling.
//                Optional macro MULDIV_EARLY_TERM_EN lets a multiply leave
//                the iteration loop once the remaining multiplier is zero.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ex_muldiv_unit #(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Start,
    input  logic [2:0]       in_Op,
    input  logic [NBits-1:0] in_ReadData1,
    input  logic [NBits-1:0] in_ReadData2,
    input  logic             in_Flush,
    output logic             out_Stall,
    output logic             out_Busy,
    output logic             out_Done,
    output logic             out_DivByZero,
    output logic [NBits-1:0] out_HI,
    output logic [NBits-1:0] out_LO
);

    localparam int         c_CNT_W   = $clog2(NBits) + 1;
    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [c_CNT_W-1:0]   r_count;
    logic [2*NBits-1:0]   r_acc;      // mul: running product; div: {remainder, dividend/quotient}
    logic [2*NBits-1:0]   r_opA;      // mul: shifted multiplicand; div: divisor in low half
    logic [NBits-1:0]     r_opB;      // mul: remaining multiplier
    logic                 r_isDiv;
    logic                 r_negLo;    // negate product (mul) or quotient (div)
    logic                 r_negHi;    // negate remainder (div)
    logic                 r_divZero;
    logic [NBits-1:0]     r_hi;
    logic [NBits-1:0]     r_lo;
    logic                 r_done;
    logic                 r_doneDbz;

    logic                 w_isMulDiv;
    logic                 w_signedOp;
    logic                 w_launch;
    logic                 w_mtWrite;
    logic [NBits-1:0]     w_absA;
    logic [NBits-1:0]     w_absB;
    logic                 w_lastStep;
    logic [2*NBits-1:0]   w_mulAcc;
    logic [NBits:0]       w_remShift;
    logic                 w_subOk;
    logic [NBits-1:0]     w_sub;
    logic [NBits-1:0]     w_remNext;
    logic [2*NBits-1:0]   w_divAcc;
    logic [2*NBits-1:0]   w_prodFix;
    logic [NBits-1:0]     w_quotFix;
    logic [NBits-1:0]     w_remFix;

    // ------------------------------------------------------------------
    // Launch decode and operand magnitudes
    // ------------------------------------------------------------------
    assign w_isMulDiv = ~in_Op[2];
    assign w_signedOp = ~in_Op[0];
    assign w_launch   = (r_state == IDLE) && in_Start && w_isMulDiv && !in_Flush;
    assign w_mtWrite  = (r_state == IDLE) && in_Start && !in_Flush;
    assign w_absA     = (w_signedOp && in_ReadData1[NBits-1]) ? -in_ReadData1 : in_ReadData1;
    assign w_absB     = (w_signedOp && in_ReadData2[NBits-1]) ? -in_ReadData2 : in_ReadData2;

    // A multiply with early termination stops once no multiplier bits remain after this step
`ifdef MULDIV_EARLY_TERM_EN
    assign w_lastStep = (r_count == c_CNT_W'(NBits - 1)) ||
                        (!r_isDiv && (r_opB[NBits-1:1] == '0));
`else
    assign w_lastStep = (r_count == c_CNT_W'(NBits - 1));
`endif

    // ------------------------------------------------------------------
    // One iteration step of each algorithm
    // ------------------------------------------------------------------
    assign w_mulAcc   = r_opB[0] ? (r_acc + r_opA) : r_acc;

    // Restoring divide: shift next dividend bit into the remainder, subtract if it fits
    assign w_remShift = r_acc[2*NBits-1:NBits-1];
    assign w_subOk    = w_remShift[NBits] || (w_remShift[NBits-1:0] >= r_opA[NBits-1:0]);
    assign w_sub      = w_remShift[NBits-1:0] - r_opA[NBits-1:0];
    assign w_remNext  = w_subOk ? w_sub : w_remShift[NBits-1:0];
    assign w_divAcc   = {w_remNext, r_acc[NBits-2:0], w_subOk};

    // Sign correction applied in FIXUP
    assign w_prodFix  = r_negLo ? -r_acc : r_acc;
    assign w_quotFix  = r_divZero ? {NBits{1'b1}} :
                        (r_negLo ? -r_acc[NBits-1:0] : r_acc[NBits-1:0]);
    // Divide by zero leaves |dividend| here; restoring its sign gives back the dividend
    assign w_remFix   = r_negHi ? -r_acc[2*NBits-1:NBits] : r_acc[2*NBits-1:NBits];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and stall decode; flush wins over everything in flight
    always_comb begin
        w_nextState = r_state;
        out_Stall   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_nextState = BUSY;
                    out_Stall   = 1'b1;
                end
            end
            BUSY: begin
                if (in_Flush) begin
                    w_nextState = IDLE;
                end else begin
                    out_Stall = 1'b1;
                    if (w_lastStep) begin
                        w_nextState = FIXUP;
                    end
                end
            end
            FIXUP: begin
                w_nextState = IDLE;
                out_Stall   = !in_Flush;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Iteration datapath: operand capture at launch, one step per BUSY cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_isDiv   <= 1'b0;
            r_negLo   <= 1'b0;
            r_negHi   <= 1'b0;
            r_divZero <= 1'b0;
        end else if (w_launch) begin
            r_count   <= '0;
            r_isDiv   <= in_Op[1];
            r_opB     <= w_absB;
            r_opA     <= {{NBits{1'b0}}, in_Op[1] ? w_absB : w_absA};
            r_acc     <= in_Op[1] ? {{NBits{1'b0}}, w_absA} : '0;
            r_divZero <= in_Op[1] && (in_ReadData2 == '0);
            r_negLo   <= w_signedOp && (in_ReadData1[NBits-1] ^ in_ReadData2[NBits-1]) &&
                         !(in_Op[1] && (in_ReadData2 == '0));
            r_negHi   <= w_signedOp && in_Op[1] && in_ReadData1[NBits-1];
        end else if ((r_state == BUSY) && !in_Flush) begin
            r_count <= r_count + c_CNT_W'(1);
            if (r_isDiv) begin
                r_acc <= w_divAcc;
            end else begin
                r_acc <= w_mulAcc;
                r_opA <= r_opA << 1;
                r_opB <= r_opB >> 1;
            end
        end
    end

    // Architectural HI/LO plus the registered completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_doneDbz <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_doneDbz <= 1'b0;
            if (w_mtWrite && (in_Op == c_OP_MTHI)) begin
                r_hi <= in_ReadData1;
            end
            if (w_mtWrite && (in_Op == c_OP_MTLO)) begin
                r_lo <= in_ReadData1;
            end
            if ((r_state == FIXUP) && !in_Flush) begin
                r_done    <= 1'b1;
                r_doneDbz <= r_divZero;
                if (r_isDiv) begin
                    r_hi <= w_remFix;
                    r_lo <= w_quotFix;
                end else begin
                    r_hi <= w_prodFix[2*NBits-1:NBits];
                    r_lo <= w_prodFix[NBits-1:0];
                end
            end
        end
    end

    assign out_Busy      = (r_state != IDLE);
    assign out_Done      = r_done;
    assign out_DivByZero = r_doneDbz;
    assign out_HI        = r_hi;
    assign out_LO        = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Self-checking bench for ex_muldiv_unit. Directed cases plus
//                randomized mul/div/mt ops compared against an arithmetic
//                reference model of HI/LO, divide-by-zero and latency.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ex_muldiv_unit;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_Start;
    logic [2:0]    in_Op;
    logic [NB-1:0] in_ReadData1;
    logic [NB-1:0] in_ReadData2;
    logic          in_Flush;
    logic          out_Stall;
    logic          out_Busy;
    logic          out_Done;
    logic          out_DivByZero;
    logic [NB-1:0] out_HI;
    logic [NB-1:0] out_LO;

    int            checks   = 0;
    int            failures = 0;
    logic [NB-1:0] mHi = '0;
    logic [NB-1:0] mLo = '0;

    ex_muldiv_unit #(.NBits(NB)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_Start      (in_Start),
        .in_Op         (in_Op),
        .in_ReadData1  (in_ReadData1),
        .in_ReadData2  (in_ReadData2),
        .in_Flush      (in_Flush),
        .out_Stall     (out_Stall),
        .out_Busy      (out_Busy),
        .out_Done      (out_Done),
        .out_DivByZero (out_DivByZero),
        .out_HI        (out_HI),
        .out_LO        (out_LO)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition of each op
    function automatic void refModel(input logic [2:0] op, input logic [NB-1:0] a,
                                     input logic [NB-1:0] b, output logic [NB-1:0] hi,
                                     output logic [NB-1:0] lo, output logic dbz,
                                     output int lat);
        longint        sa;
        longint        sb;
        logic [63:0]   wide;
        logic [NB-1:0] mag;
        int            steps;
        hi   = '0;
        lo   = '0;
        dbz  = 1'b0;
        lat  = NB + 2;
        wide = '0;
        case (op)
            3'd0: begin
                sa   = longint'($signed(a));
                sb   = longint'($signed(b));
                wide = 64'(sa * sb);
                hi   = wide[63:32];
                lo   = wide[31:0];
            end
            3'd1: begin
                wide = {32'b0, a} * {32'b0, b};
                hi   = wide[63:32];
                lo   = wide[31:0];
            end
            default: begin
                if (b == '0) begin
                    hi  = a;
                    lo  = '1;
                    dbz = 1'b1;
                end else if (op == 3'd2) begin
                    sa   = longint'($signed(a));
                    sb   = longint'($signed(b));
                    wide = 64'(sa / sb);
                    lo   = wide[31:0];
                    wide = 64'(sa % sb);
                    hi   = wide[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
`ifdef MULDIV_EARLY_TERM_EN
        if (op <= 3'd1) begin
            mag   = (op == 3'd0 && b[NB-1]) ? -b : b;
            steps = 1;
            while (steps < NB && (mag >> steps) != '0) steps++;
            lat = steps + 2;
        end
`else
        mag   = b;
        steps = 0;
`endif
    endfunction

    function automatic logic [NB-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    task automatic runMulDiv(input string tag, input logic [2:0] op,
                             input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic [NB-1:0] eHi;
        logic [NB-1:0] eLo;
        logic          eDbz;
        int            lat;
        int            cyc;
        int            stallCnt;
        logic          seen;
        refModel(op, a, b, eHi, eLo, eDbz, lat);
        @(posedge clk); #1;
        in_Start = 1'b1; in_Op = op; in_ReadData1 = a; in_ReadData2 = b;
        #1;
        checkEq({tag, "_stall_start"}, 64'(out_Stall), 64'd1);
        stallCnt = 1;
        seen     = 1'b0;
        @(posedge clk); #1;
        in_Start = 1'b0; in_ReadData1 = $urandom; in_ReadData2 = $urandom;
        cyc = 1;
        while (cyc < 200) begin
            if (out_Done) begin
                seen = 1'b1;
                break;
            end
            if (out_Stall) stallCnt++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!seen) begin
            checkEq({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            checkEq({tag, "_latency"}, 64'(cyc), 64'(lat));
            checkEq({tag, "_stall_cycles"}, 64'(stallCnt), 64'(lat));
            checkEq({tag, "_stall_at_done"}, 64'(out_Stall), 64'd0);
            checkEq({tag, "_hi"}, 64'(out_HI), 64'(eHi));
            checkEq({tag, "_lo"}, 64'(out_LO), 64'(eLo));
            checkEq({tag, "_dbz"}, 64'(out_DivByZero), 64'(eDbz));
            @(posedge clk); #1;
            checkEq({tag, "_done_pulse"}, 64'(out_Done), 64'd0);
        end
        mHi = eHi;
        mLo = eLo;
    endtask

    task automatic runMt(input string tag, input logic [2:0] op, input logic [NB-1:0] v);
        @(posedge clk); #1;
        in_Start = 1'b1; in_Op = op; in_ReadData1 = v; in_ReadData2 = $urandom;
        #1;
        checkEq({tag, "_stall"}, 64'(out_Stall), 64'd0);
        @(posedge clk); #1;
        in_Start = 1'b0;
        if (op == 3'b100) mHi = v;
        else              mLo = v;
        checkEq({tag, "_hi"}, 64'(out_HI), 64'(mHi));
        checkEq({tag, "_lo"}, 64'(out_LO), 64'(mLo));
        checkEq({tag, "_no_done"}, 64'(out_Done), 64'd0);
    endtask

    initial begin
        int doneCnt;
        reset = 1'b1; in_Start = 1'b0; in_Op = '0; in_Flush = 1'b0;
        in_ReadData1 = '0; in_ReadData2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("reset_outputs", {out_HI, out_LO},
                {mHi, mLo});
        checkEq("reset_flags", {60'd0, out_Done, out_DivByZero, out_Busy, out_Stall}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        runMulDiv("mult_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        runMulDiv("divu_100_7", 3'd3, 32'd100, 32'd7);
        runMulDiv("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
        runMulDiv("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        runMulDiv("divu_5_0", 3'd3, 32'd5, 32'd0);
        runMulDiv("div_m9_0", 3'd2, 32'hFFFF_FFF7, 32'd0);
        runMulDiv("multu_3_2", 3'd1, 32'd3, 32'd2);
        runMulDiv("mult_min_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
        runMt("mtlo", 3'b101, 32'h1234);
        runMt("mthi", 3'b100, 32'hCAFE_F00D);

        // Reserved op codes do nothing
        @(posedge clk); #1;
        in_Start = 1'b1; in_Op = 3'b110; in_ReadData1 = $urandom;
        #1;
        checkEq("op6_stall", 64'(out_Stall), 64'd0);
        @(posedge clk); #1;
        in_Start = 1'b0;
        checkEq("op6_state", {30'd0, out_Busy, out_Done, out_HI}, {32'd0, mHi});
        checkEq("op6_lo", 64'(out_LO), 64'(mLo));

        // Flush in IDLE blocks a same-cycle launch
        @(posedge clk); #1;
        in_Start = 1'b1; in_Flush = 1'b1; in_Op = 3'd3; in_ReadData1 = 32'd50; in_ReadData2 = 32'd3;
        #1;
        checkEq("idle_flush_stall", 64'(out_Stall), 64'd0);
        @(posedge clk); #1;
        in_Start = 1'b0; in_Flush = 1'b0;
        checkEq("idle_flush_busy", 64'(out_Busy), 64'd0);

        // Flush mid-multiply: back to IDLE, HI/LO untouched, no completion
        @(posedge clk); #1;
        in_Start = 1'b1; in_Op = 3'd1; in_ReadData1 = $urandom; in_ReadData2 = 32'hFFFF_0001;
        @(posedge clk); #1;
        in_Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkEq("flush_pre_busy", 64'(out_Busy), 64'd1);
        in_Flush = 1'b1;
        #1;
        checkEq("flush_stall_drop", 64'(out_Stall), 64'd0);
        @(posedge clk); #1;
        in_Flush = 1'b0;
        checkEq("flush_busy", 64'(out_Busy), 64'd0);
        doneCnt = 0;
        for (int i = 0; i < NB + 4; i++) begin
            if (out_Done) doneCnt++;
            @(posedge clk); #1;
        end
        checkEq("flush_no_done", 64'(doneCnt), 64'd0);
        checkEq("flush_hilo", {out_HI, out_LO}, {mHi, mLo});

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [2:0]    op;
            logic [NB-1:0] a;
            logic [NB-1:0] b;
            op = 3'($urandom_range(0, 5));
            a  = pickOperand();
            b  = pickOperand();
            if (op >= 3'd4) runMt("rnd_mt", op, a);
            else            runMulDiv("rnd_op", op, a, b);
        end

        // Asynchronous reset in the middle of an operation
        runMt("pre_rst_hi", 3'b100, 32'h5555_AAAA);
        @(posedge clk); #1;
        in_Start = 1'b1; in_Op = 3'd0; in_ReadData1 = 32'd12345; in_ReadData2 = 32'd678;
        @(posedge clk); #1;
        in_Start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkEq("async_rst_hilo", {out_HI, out_LO}, 64'd0);
        checkEq("async_rst_flags", {60'd0, out_Done, out_DivByZero, out_Busy, out_Stall}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mHi = '0;
        mLo = '0;
        runMulDiv("post_rst_div", 3'd2, 32'd1000, 32'hFFFF_FFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
